reg_file_mp: RTL and testbench

Parametrised multi-lane register file for the superscalar pipeline, the successor to the fixed two-lane, 32x32 file. It provides LANES write ports and 2*LANES registered read ports, with write-to-read forwarding and intra-bundle write priority. It also keeps a per-register busy scoreboard that issue logic uses to detect outstanding producers. It sits between decode/issue (read, reserve) and writeback (write, clear).

---
 rtl/reg_file_mp.sv | 129 ++++++++++++
 tb/tb_reg_file_mp.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
`timescale 1ns/1ps
// reg_file_mp: parametrised multi-lane register file with forwarding and busy scoreboard.
//   clk, reset (async active-low)
//   wr_en/wr_addr/wr_data   : LANES writeback ports, highest lane wins on same address
//   rd_addr -> rd_data      : 2*LANES read ports, one-cycle registered latency, write forwarding
//   rd_busy                 : registered busy flag of each read address (write clears seen, reservations not)
//   rsv_en/rsv_addr         : LANES destination reservations (set busy)
//   flush                   : synchronous clear of every busy bit
//   busy_cnt                : registered population count of the busy vector
module reg_file_mp #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned LANES      = 2,
  parameter int unsigned RESET_INIT = 1,
  localparam int unsigned ADDR_W    = $clog2(NUM_REGS),
  localparam int unsigned PORTS     = 2 * LANES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES-1:0]          wr_en,
  input  logic [LANES*ADDR_W-1:0]   wr_addr,
  input  logic [LANES*DATA_W-1:0]   wr_data,
  input  logic [PORTS*ADDR_W-1:0]   rd_addr,
  output logic [PORTS*DATA_W-1:0]   rd_data,
  output logic [PORTS-1:0]          rd_busy,
  input  logic [LANES-1:0]          rsv_en,
  input  logic [LANES*ADDR_W-1:0]   rsv_addr,
  input  logic                      flush,
  output logic [ADDR_W:0]           busy_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic [ADDR_W-1:0]   wa_c  [LANES];
  logic [DATA_W-1:0]   wd_c  [LANES];
  logic [ADDR_W-1:0]   sa_c  [LANES];
  logic [ADDR_W-1:0]   ra_c  [PORTS];

  logic [NUM_REGS-1:0] wr_hit_c;
  logic [NUM_REGS-1:0] rsv_hit_c;
  logic [NUM_REGS-1:0] busy_clr_c;
  logic [NUM_REGS-1:0] busy_nxt_c;
  logic [CNT_W-1:0]    cnt_nxt_c;

  logic [PORTS*DATA_W-1:0] rd_data_nxt_c;
  logic [PORTS-1:0]        rd_busy_nxt_c;

  // Unpack the flat lane/port buses.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      wa_c[k] = wr_addr[k*ADDR_W +: ADDR_W];
      wd_c[k] = wr_data[k*DATA_W +: DATA_W];
      sa_c[k] = rsv_addr[k*ADDR_W +: ADDR_W];
    end
    for (int p = 0; p < int'(PORTS); p++) begin
      ra_c[p] = rd_addr[p*ADDR_W +: ADDR_W];
    end
  end

  // Per-register write and reservation hit masks; register 0 never participates.
  always_comb begin
    wr_hit_c  = '0;
    rsv_hit_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (wr_en[k])  wr_hit_c[wa_c[k]]  = 1'b1;
      if (rsv_en[k]) rsv_hit_c[sa_c[k]] = 1'b1;
    end
    wr_hit_c[0]  = 1'b0;
    rsv_hit_c[0] = 1'b0;
  end

  // Scoreboard next state: flush over reservation over write clear.
  always_comb begin
    busy_clr_c = busy & ~wr_hit_c;
    busy_nxt_c = flush ? '0 : (busy_clr_c | rsv_hit_c);
    cnt_nxt_c  = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      cnt_nxt_c = cnt_nxt_c + CNT_W'(busy_nxt_c[r]);
    end
  end

  // Read value selection: zero register, then forwarding (highest lane last), then array.
  always_comb begin
    rd_data_nxt_c = '0;
    rd_busy_nxt_c = '0;
    for (int p = 0; p < int'(PORTS); p++) begin
      logic [DATA_W-1:0] val;
      val = regs[ra_c[p]];
      for (int k = 0; k < int'(LANES); k++) begin
        if (wr_en[k] && (wa_c[k] == ra_c[p])) val = wd_c[k];
      end
      if (ra_c[p] == '0) val = '0;
      rd_data_nxt_c[p*DATA_W +: DATA_W] = val;
      rd_busy_nxt_c[p] = flush ? 1'b0 : busy_clr_c[ra_c[p]];
    end
  end

  // Architectural array; ascending lane loop lets the highest lane's NBA win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= ((RESET_INIT != 0) && (i != 0)) ? DATA_W'(i) : '0;
      end
    end else begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (wr_en[k] && (wa_c[k] != '0)) regs[wa_c[k]] <= wd_c[k];
      end
    end
  end

  // Scoreboard and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      rd_data  <= '0;
      rd_busy  <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt_c;
      rd_data  <= rd_data_nxt_c;
      rd_busy  <= rd_busy_nxt_c;
      busy_cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
`timescale 1ns/1ps
// Scoreboard bench for reg_file_mp (default parameters, RESET_INIT=1).
module tb_reg_file_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PORTS  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LANES-1:0]        wr_en;
  logic [LANES*ADDR_W-1:0] wr_addr;
  logic [LANES*DATA_W-1:0] wr_data;
  logic [PORTS*ADDR_W-1:0] rd_addr;
  logic [PORTS*DATA_W-1:0] rd_data;
  logic [PORTS-1:0]        rd_busy;
  logic [LANES-1:0]        rsv_en;
  logic [LANES*ADDR_W-1:0] rsv_addr;
  logic                    flush;
  logic [ADDR_W:0]         busy_cnt;

  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .LANES(2), .RESET_INIT(1)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // kind 0: rd_data[port], 1: rd_busy[port], 2: busy_cnt
  typedef struct {
    int          due;
    int          kind;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   tests    = 0;
  int   fails    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int kind, input int port);
    case (kind)
      0:       return rd_data[port*DATA_W +: DATA_W];
      1:       return 32'(rd_busy[port]);
      default: return 32'(busy_cnt);
    endcase
  endfunction

  // Monitor: compare every expectation whose registering edge has passed.
  always begin
    @(negedge clk);
    #1;
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, actual(e.kind, e.port), e.val);
    end
  end

  task automatic push(input int lat, input int kind, input int port, input logic [31:0] v,
                      input string name);
    exp_t e;
    e.due = edge_cnt + lat; e.kind = kind; e.port = port; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_data(input int p, input logic [31:0] v, input string n);
    push(1, 0, p, v, n);
  endtask
  task automatic exp_busy(input int p, input logic b, input string n);
    push(1, 1, p, 32'(b), n);
  endtask
  task automatic exp_cnt(input int v, input string n);
    push(1, 2, 0, 32'(v), n);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    rsv_en = '0; rsv_addr = '0; flush = 1'b0;
  endtask
  task automatic rd(input int p, input int a);
    rd_addr[p*ADDR_W +: ADDR_W] = 5'(a);
  endtask
  task automatic wr(input int k, input int a, input logic [31:0] d);
    wr_en[k] = 1'b1; wr_addr[k*ADDR_W +: ADDR_W] = 5'(a); wr_data[k*DATA_W +: DATA_W] = d;
  endtask
  task automatic rsv(input int k, input int a);
    rsv_en[k] = 1'b1; rsv_addr[k*ADDR_W +: ADDR_W] = 5'(a);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      push(0, 0, p, 32'h0, "reset_rd_data");
      push(0, 1, p, 32'h0, "reset_rd_busy");
    end
    push(0, 2, 0, 32'h0, "reset_busy_cnt");

    // Reset values via reads
    @(negedge clk); reset = 1'b1; idle();
    rd(0, 5); rd(1, 31); rd(2, 0); rd(3, 1);
    exp_data(0, 5, "init_r5"); exp_data(1, 31, "init_r31");
    exp_data(2, 0, "init_r0"); exp_data(3, 1, "init_r1");
    exp_cnt(0, "init_cnt");

    // Same-address write conflict with forwarding
    @(negedge clk); idle();
    wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(0, 7);
    exp_data(0, 32'h5555, "conflict_fwd");
    @(negedge clk); idle();
    rd(0, 7); rd(1, 5);
    exp_data(0, 32'h5555, "conflict_stored"); exp_data(1, 5, "r5_untouched");

    // Write and reserve to register 0
    @(negedge clk); idle();
    wr(0, 0, 32'hFFFF_FFFF); rsv(0, 0); rd(0, 0);
    exp_data(0, 0, "r0_fwd"); exp_busy(0, 1'b0, "r0_busy_fwd"); exp_cnt(0, "r0_cnt_a");
    @(negedge clk); idle();
    rd(0, 0);
    exp_data(0, 0, "r0_read"); exp_busy(0, 1'b0, "r0_busy"); exp_cnt(0, "r0_cnt_b");

    // Scoreboard set and clear
    @(negedge clk); idle();
    rsv(0, 3); rd(0, 3);
    exp_busy(0, 1'b0, "rsv3_same_cycle"); exp_cnt(1, "rsv3_cnt");
    @(negedge clk); idle();
    rd(0, 3);
    exp_busy(0, 1'b1, "rsv3_busy"); exp_data(0, 3, "rsv3_data"); exp_cnt(1, "rsv3_cnt_hold");
    @(negedge clk); idle();
    wr(1, 3, 32'h1234); rd(0, 3);
    exp_busy(0, 1'b0, "wr3_busy_clr"); exp_data(0, 32'h1234, "wr3_data"); exp_cnt(0, "wr3_cnt");

    // Reserve and write same register same cycle
    @(negedge clk); idle();
    rsv(0, 9); wr(1, 9, 32'h99); rd(0, 9);
    exp_data(0, 32'h99, "rw9_fwd"); exp_busy(0, 1'b0, "rw9_busy_pre"); exp_cnt(1, "rw9_cnt");
    @(negedge clk); idle();
    rd(0, 9);
    exp_data(0, 32'h99, "rw9_data"); exp_busy(0, 1'b1, "rw9_busy"); exp_cnt(1, "rw9_cnt_hold");

    // Retire 9, then reserve 4,5,6
    @(negedge clk); idle();
    wr(0, 9, 32'h77); rd(1, 9);
    exp_data(1, 32'h77, "wr9_data"); exp_busy(1, 1'b0, "wr9_busy"); exp_cnt(0, "wr9_cnt");
    @(negedge clk); idle();
    rsv(0, 4); rsv(1, 5);
    exp_cnt(2, "rsv45_cnt");
    @(negedge clk); idle();
    rsv(0, 6); rd(0, 4); rd(1, 5); rd(2, 6);
    exp_busy(0, 1'b1, "busy4"); exp_busy(1, 1'b1, "busy5"); exp_busy(2, 1'b0, "busy6_hidden");
    exp_cnt(3, "rsv456_cnt");

    // Flush beats a same-cycle reservation
    @(negedge clk); idle();
    flush = 1'b1; rsv(0, 8); rd(0, 4);
    exp_busy(0, 1'b0, "flush_busy4"); exp_cnt(0, "flush_cnt");
    @(negedge clk); idle();
    rd(0, 8); rd(1, 6);
    exp_busy(0, 1'b0, "flush_busy8"); exp_busy(1, 1'b0, "flush_busy6"); exp_cnt(0, "flush_cnt_hold");

    // Distinct-lane writes with forwarding on all ports
    @(negedge clk); idle();
    wr(0, 10, 32'hA); wr(1, 11, 32'hB); rd(0, 10); rd(1, 11); rd(2, 12); rd(3, 31);
    exp_data(0, 32'hA, "fwd_l0"); exp_data(1, 32'hB, "fwd_l1");
    exp_data(2, 12, "plain_r12"); exp_data(3, 31, "plain_r31");

    // Async reset between edges
    @(negedge clk); idle();
    rsv(0, 2); rd(0, 31);
    exp_data(0, 31, "pre_reset_data"); exp_cnt(1, "pre_reset_cnt");
    @(negedge clk); idle();
    rd(0, 31);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rd_data0", rd_data[DATA_W-1:0], 32'h0);
    check("async_busy_cnt", 32'(busy_cnt), 32'h0);
    @(negedge clk); reset = 1'b1; idle();
    rd(0, 10); rd(1, 2);
    exp_data(0, 10, "post_reset_r10"); exp_busy(1, 1'b0, "post_reset_busy2");
    exp_cnt(0, "post_reset_cnt");

    @(negedge clk); idle();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
